// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared helpers for the multi-channel clock divider
package clk_div_pkg;

    function automatic int clog2(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic longint default_period(input longint fin, input longint fout);
        return fin / fout;
    endfunction

    function automatic longint default_high(input longint fin, input longint fout);
        return default_period(fin, fout) / 2;
    endfunction

    function automatic logic cfg_ok(input logic [63:0] ch, input logic [63:0] n_ch,
                                    input logic [63:0] per, input logic [63:0] hi);
        return ch < n_ch && per >= 64'd2 && hi >= 64'd1 && hi < per;
    endfunction

endpackage

// File: rtl/clk_div_channel.sv
// clk_div_channel: one divided clock with double-buffered period/high settings
module clk_div_channel
    import clk_div_pkg::*;
#(
    parameter int               DIV_W   = 27,
    parameter logic [DIV_W-1:0] DEF_PER = DIV_W'(4),
    parameter logic [DIV_W-1:0] DEF_HI  = DIV_W'(2)
) (
    input  logic             clk100MHz,
    input  logic             rst,
    input  logic             en,
    input  logic             ld,
    input  logic [DIV_W-1:0] per_in,
    input  logic [DIV_W-1:0] hi_in,
    output logic             clk_div,
    output logic             tick
);

    logic [DIV_W-1:0] count, per_a, hi_a, per_p, hi_p;
    logic [DIV_W-1:0] cnt_n, pa_n, ha_n;
    logic             wrap;

    always_comb begin
        wrap  = count == per_a - DIV_W'(1);
        cnt_n = !en ? per_a - DIV_W'(1) : wrap ? '0 : count + DIV_W'(1);
        pa_n  = en && wrap ? per_p : per_a;
        ha_n  = en && wrap ? hi_p : hi_a;
    end

    // A disabled channel parks at per_a-1 so its first enabled edge is a wrap
    always_ff @(posedge clk100MHz) begin
        if (rst) begin
            count   <= DEF_PER - DIV_W'(1);
            per_a   <= DEF_PER;
            hi_a    <= DEF_HI;
            per_p   <= DEF_PER;
            hi_p    <= DEF_HI;
            clk_div <= 1'b0;
            tick    <= 1'b0;
        end else begin
            count   <= cnt_n;
            per_a   <= pa_n;
            hi_a    <= ha_n;
            clk_div <= en && cnt_n < ha_n;
            tick    <= en && wrap;
            if (ld) begin
                per_p <= per_in;
                hi_p  <= hi_in;
            end
        end
    end

endmodule

// File: rtl/clk_div_multi.sv
// clk_div_multi: N_CH programmable clock/tick generators with validated config writes
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter longint CLK_IN_FREQ      = 100_000_000,
    parameter longint DEFAULT_OUT_FREQ = 25_000_000,
    parameter int     N_CH             = 4,
    parameter int     DIV_W            = 27,
    localparam int    CH_W             = clog2(N_CH) < 1 ? 1 : clog2(N_CH)
) (
    input  logic             clk100MHz,
    input  logic             rst,
    input  logic [N_CH-1:0]  en,
    input  logic             cfg_we,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [DIV_W-1:0] cfg_period,
    input  logic [DIV_W-1:0] cfg_high,
    output logic [N_CH-1:0]  clk_div,
    output logic [N_CH-1:0]  tick,
    output logic             cfg_err
);

    localparam longint DEF_PER_L = default_period(CLK_IN_FREQ, DEFAULT_OUT_FREQ);
    localparam logic [DIV_W-1:0] DEF_PER = DIV_W'(DEF_PER_L);
    localparam logic [DIV_W-1:0] DEF_HI  = DIV_W'(default_high(CLK_IN_FREQ, DEFAULT_OUT_FREQ));

    if (DEF_PER_L >= (64'sd1 <<< DIV_W)) begin : g_bad_default
        $error("DEFAULT_PERIOD does not fit in DIV_W bits");
    end

    logic            ok;
    logic [N_CH-1:0] ld;

    assign ok = cfg_ok(64'(cfg_ch), 64'(N_CH), 64'(cfg_period), 64'(cfg_high));

    always_ff @(posedge clk100MHz) begin
        cfg_err <= rst ? 1'b0 : cfg_we && !ok;
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        assign ld[i] = cfg_we && ok && cfg_ch == CH_W'(i);
        clk_div_channel #(
            .DIV_W  (DIV_W),
            .DEF_PER(DEF_PER),
            .DEF_HI (DEF_HI)
        ) u_ch (
            .clk100MHz(clk100MHz),
            .rst      (rst),
            .en       (en[i]),
            .ld       (ld[i]),
            .per_in   (cfg_period),
            .hi_in    (cfg_high),
            .clk_div  (clk_div[i]),
            .tick     (tick[i])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// tb_clk_div_multi: scoreboard bench comparing clk_div/tick/cfg_err against a cycle model
module tb_clk_div_multi;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  en = '0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_ch = '0;
    logic [26:0] cfg_period = '0;
    logic [26:0] cfg_high = '0;
    logic [3:0]  clk_div, tick;
    logic        cfg_err;
    logic [2:0]  clk_div3, tick3;
    logic        cfg_err3;

    int total = 0;
    int bad = 0;

    int m_cnt[4], m_pa[4], m_ha[4], m_pp[4], m_hp[4];
    logic [3:0] m_cd;
    logic [9:0] sb[$];

    always #5 clk = ~clk;

    clk_div_multi dut (
        .clk100MHz(clk), .rst(rst), .en(en), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_period(cfg_period), .cfg_high(cfg_high),
        .clk_div(clk_div), .tick(tick), .cfg_err(cfg_err)
    );

    clk_div_multi #(.N_CH(3)) dut3 (
        .clk100MHz(clk), .rst(rst), .en(en[2:0]), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_period(cfg_period), .cfg_high(cfg_high),
        .clk_div(clk_div3), .tick(tick3), .cfg_err(cfg_err3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        logic [3:0] ecd, etk;
        logic       valid, w, eerr, eerr3;
        logic [9:0] e;
        valid = cfg_period >= 2 && cfg_high >= 1 && cfg_high < cfg_period;
        eerr  = !rst && cfg_we && !valid;
        eerr3 = !rst && cfg_we && !(valid && cfg_ch < 3);
        for (int c = 0; c < 4; c++) begin
            if (rst) begin
                m_cnt[c] = 3; m_pa[c] = 4; m_ha[c] = 2; m_pp[c] = 4; m_hp[c] = 2;
                ecd[c] = 1'b0; etk[c] = 1'b0;
            end else begin
                w = m_cnt[c] == m_pa[c] - 1;
                if (!en[c]) begin
                    m_cnt[c] = m_pa[c] - 1; ecd[c] = 1'b0; etk[c] = 1'b0;
                end else begin
                    if (w) begin
                        m_cnt[c] = 0; m_pa[c] = m_pp[c]; m_ha[c] = m_hp[c];
                    end else m_cnt[c]++;
                    ecd[c] = m_cnt[c] < m_ha[c];
                    etk[c] = w;
                end
                if (cfg_we && valid && cfg_ch == 2'(c)) begin
                    m_pp[c] = int'(cfg_period); m_hp[c] = int'(cfg_high);
                end
            end
        end
        m_cd = ecd;
        sb.push_back({ecd, etk, eerr, eerr3});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("clk_div", 32'(clk_div), 32'(e[9:6]));
        check("tick", 32'(tick), 32'(e[5:2]));
        check("cfg_err", 32'(cfg_err), 32'(e[1]));
        check("cfg_err_n3", 32'(cfg_err3), 32'(e[0]));
        cfg_we = 1'b0;
    endtask

    task automatic cfg(input logic [1:0] ch, input int per, input int hi);
        cfg_we = 1'b1; cfg_ch = ch; cfg_period = 27'(per); cfg_high = 27'(hi);
        step();
    endtask

    initial begin
        repeat (2) step();
        check("rst_clk_div", 32'(clk_div), 32'h0);
        check("rst_cfg_err", 32'(cfg_err), 32'h0);
        rst = 1'b0;
        step();
        en = 4'b1111;
        step();
        check("first_rise", 32'(clk_div), 32'hf);
        check("first_tick", 32'(tick), 32'hf);
        repeat (5) step();
        cfg(2'd1, 5, 2);
        repeat (12) step();
        for (int k = 0; k < 20 && m_cnt[2] != m_pa[2] - 1; k++) step();
        cfg(2'd2, 6, 3);
        repeat (14) step();
        cfg(2'd0, 1, 1);
        step();
        cfg(2'd1, 5, 0);
        cfg(2'd2, 4, 4);
        step();
        cfg(2'd3, 5, 3);
        repeat (3) step();
        for (int k = 0; k < 20 && !m_cd[0]; k++) step();
        check("cd0_high_before_drop", 32'(clk_div[0]), 32'h1);
        en[0] = 1'b0;
        step();
        check("cd0_dropped", 32'(clk_div[0]), 32'h0);
        step();
        en[0] = 1'b1;
        step();
        check("cd0_restart", 32'(clk_div[0]), 32'h1);
        check("tick0_restart", 32'(tick[0]), 32'h1);
        repeat (4) step();
        cfg(2'd3, 7, 5);
        step();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        repeat (12) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
